// File: rtl/sram_rom_reader_if.sv
// Bus bundle for sram_rom_reader: control, ROM read port and output stream.
// The reader side uses the master modport; the ROM/consumer/controller side uses slave.
interface sram_rom_reader_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1024
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic             start;
  logic [AW-1:0]    start_addr;
  logic [CW-1:0]    count;
  logic             busy;
  logic             done;
  logic             rom_en;
  logic [AW-1:0]    rom_addr;
  logic [WIDTH-1:0] rom_do;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  logic             out_ready;

  modport master (
    input  start, start_addr, count, rom_do, out_ready,
    output busy, done, rom_en, rom_addr, out_valid, out_data, out_last
  );

  modport slave (
    output start, start_addr, count, rom_do, out_ready,
    input  busy, done, rom_en, rom_addr, out_valid, out_data, out_last
  );
endinterface

// File: rtl/sram_rom_reader.sv
// Streams COUNT consecutive words out of a 1-cycle-latency ROM as valid/ready,
// one word per clock when the sink keeps up.
module sram_rom_reader #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  sram_rom_reader_if.master   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, ZERO, RUN} state_t;

  state_t        state, state_nx;
  logic [AW-1:0] addr;
  logic [CW-1:0] iss, rem;
  logic          vld, done_q;
  logic          issue, load, hs, last_hs;

  assign hs      = vld & bus.out_ready;
  assign last_hs = hs & (rem == CW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    issue    = 1'b0;
    load     = 1'b0;
    case (state)
      IDLE: if (bus.start) begin
        load     = 1'b1;
        state_nx = (bus.count == '0) ? ZERO : RUN;
      end
      ZERO: state_nx = IDLE;
      RUN: begin
        // Only fetch when the output slot is empty or being drained this cycle,
        // so the ROM output register doubles as the single stage of storage.
        issue = (iss != '0) & (~vld | bus.out_ready);
        if (last_hs) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr   <= '0;
      iss    <= '0;
      rem    <= '0;
      vld    <= 1'b0;
      done_q <= 1'b0;
    end else begin
      if (load) begin
        addr <= bus.start_addr;
        iss  <= bus.count;
        rem  <= bus.count;
      end else begin
        if (issue) begin
          addr <= addr + AW'(1);
          iss  <= iss - CW'(1);
        end
        if (hs) rem <= rem - CW'(1);
      end
      vld    <= issue | (vld & ~bus.out_ready);
      done_q <= (load & (bus.count == '0)) | last_hs;
    end
  end

  // ROM_EN is gated by RUN, which reset forces away, so it is low throughout reset.
  assign bus.busy      = (state == RUN);
  assign bus.done      = done_q;
  assign bus.rom_en    = issue;
  assign bus.rom_addr  = addr;
  assign bus.out_valid = vld;
  assign bus.out_data  = bus.rom_do;
  assign bus.out_last  = vld & (rem == CW'(1));
endmodule
